// File: rtl/bsword_rx.sv
// bsword_rx: bit-serial to parallel word receiver.
//
// Collects LSB-first serial words framed by a one-cycle sync pulse on bit 0,
// assembles them into LEN-bit words, and queues completed words in a
// 2-entry FIFO whose head is presented on a valid/ready interface.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (release synchronously to clk)
//   is         serial data bit, LSB first
//   isync      one-cycle pulse coincident with bit 0 of a word
//   dout       word at the FIFO head (held when dvalid is low)
//   dvalid     dout holds a valid word
//   dready     consumer ready
//   busy       a word is being assembled
//   ovf        sticky: a completed word was dropped, FIFO full
//   ferr       sticky: isync arrived mid-word
//   clr        synchronous clear of ovf/ferr (and errcnt)
//   errcnt     saturating error count (only with BSWORD_RX_ERRCNT_EN)
//   fsm_state  debug view of the assembly FSM (0 = IDLE, 1 = SHIFT)
//
// Optional feature: define BSWORD_RX_ERRCNT_EN to add the errcnt output,
// an 8-bit saturating count of dropped words plus framing errors.
//
// Handshake: a word transfers on every rising edge where dvalid & dready
// are both high. While dvalid is high and dready is low, dout and dvalid
// hold. dvalid never depends combinationally on dready.
//
// LEN must be at least 3.

module bsword_rx #(
    parameter int LEN = 24
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           is,
    input  logic           isync,
    output logic [LEN-1:0] dout,
    output logic           dvalid,
    input  logic           dready,
    output logic           busy,
    output logic           ovf,
    output logic           ferr,
    input  logic           clr,
`ifdef BSWORD_RX_ERRCNT_EN
    output logic [7:0]     errcnt,
`endif
    output logic           fsm_state
);

    localparam int CW = $clog2(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    // Holds bits 0..LEN-2 of the word in progress. Bits enter at the top and
    // shift down, so after LEN-1 bits bit 0 sits at index 0 and the final
    // bit is taken straight from the input.
    logic [LEN-2:0] sreg;

    logic [LEN-1:0] tail_word;
    logic           tail_valid;

    logic           frame_err;
    logic           word_done;
    logic [LEN-1:0] word;
    logic           pop;
    logic           full;
    logic           drop;

    // Sync while assembling: the partial word is abandoned.
    assign frame_err = (state == SHIFT) && isync;
    assign word_done = (state == SHIFT) && !isync && (cnt == LAST);
    assign word      = {is, sreg};
    assign pop       = dvalid && dready;
    assign full      = dvalid && tail_valid;
    // A push into a full FIFO survives only if the head leaves this cycle.
    assign drop      = word_done && full && !pop;

    assign busy      = (state == SHIFT);
    assign fsm_state = state;

    // Word assembly FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (isync) begin
                        sreg  <= {is, {(LEN-2){1'b0}}};
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (isync) begin
                        // Current bit becomes bit 0 of a fresh word.
                        sreg <= {is, {(LEN-2){1'b0}}};
                        cnt  <= CW'(1);
                    end else if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        sreg <= {is, sreg[LEN-2:1]};
                        cnt  <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // 2-entry FIFO: head register drives dout directly, tail is the second
    // slot. Entries are only ever filled head-first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dvalid     <= 1'b0;
            tail_word  <= '0;
            tail_valid <= 1'b0;
        end else begin
            if (!dvalid) begin
                if (word_done) begin
                    dout   <= word;
                    dvalid <= 1'b1;
                end
            end else if (!tail_valid) begin
                if (pop && word_done) begin
                    dout <= word;
                end else if (pop) begin
                    dvalid <= 1'b0;
                end else if (word_done) begin
                    tail_word  <= word;
                    tail_valid <= 1'b1;
                end
            end else begin
                if (pop) begin
                    dout <= tail_word;
                    if (word_done) begin
                        tail_word <= word;
                    end else begin
                        tail_valid <= 1'b0;
                    end
                end
            end
        end
    end

    // Sticky error flags; a new event in the same cycle as clr wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovf  <= drop | (ovf & ~clr);
            ferr <= frame_err | (ferr & ~clr);
        end
    end

`ifdef BSWORD_RX_ERRCNT_EN
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    assign err_inc = {1'b0, drop} + {1'b0, frame_err};
    assign err_sum = {1'b0, errcnt} + {7'b0, err_inc};

    // Events coinciding with clr are still counted, matching the flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            errcnt <= '0;
        end else if (clr) begin
            errcnt <= {6'b0, err_inc};
        end else begin
            errcnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_bsword_rx.sv
// Testbench for bsword_rx: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a word-level model.

module tb_bsword_rx;

    localparam int LEN = 24;

    logic           clk    = 1'b0;
    logic           reset  = 1'b0;
    logic           is     = 1'b0;
    logic           isync  = 1'b0;
    logic           dready = 1'b0;
    logic           clr    = 1'b0;
    logic [LEN-1:0] dout;
    logic           dvalid;
    logic           busy;
    logic           ovf;
    logic           ferr;
    logic           fsm_state;
`ifdef BSWORD_RX_ERRCNT_EN
    logic [7:0]     errcnt;
`endif

    int errors = 0;
    int checks = 0;
    int delivered = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    bsword_rx #(.LEN(LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .is        (is),
        .isync     (isync),
        .dout      (dout),
        .dvalid    (dvalid),
        .dready    (dready),
        .busy      (busy),
        .ovf       (ovf),
        .ferr      (ferr),
        .clr       (clr),
`ifdef BSWORD_RX_ERRCNT_EN
        .errcnt    (errcnt),
`endif
        .fsm_state (fsm_state)
    );

    // ---------------- reference model ----------------
    // Words are rebuilt bit by bit from the serial input by position; the
    // FIFO is a plain queue of at most two words.
    logic [LEN-1:0] exp_q[$];
    int             m_pos    = 0;
    logic [LEN-1:0] m_word   = '0;
    bit             m_ovf    = 1'b0;
    bit             m_ferr   = 1'b0;
    int             m_errcnt = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_pos    = 0;
            m_word   = '0;
            m_ovf    = 1'b0;
            m_ferr   = 1'b0;
            m_errcnt = 0;
        end else begin
            bit             pop;
            bit             done;
            bit             drop;
            bit             fe;
            logic [LEN-1:0] w;
            pop  = (exp_q.size() > 0) && dready;
            done = 1'b0;
            drop = 1'b0;
            fe   = 1'b0;
            w    = '0;
            if (isync) begin
                fe     = (m_pos > 0);
                m_word = '0;
                m_word[0] = is;
                m_pos  = 1;
            end else if (m_pos > 0) begin
                m_word[m_pos] = is;
                m_pos = m_pos + 1;
                if (m_pos == LEN) begin
                    done  = 1'b1;
                    w     = m_word;
                    m_pos = 0;
                end
            end
            if (done && exp_q.size() == 2 && !pop) drop = 1'b1;
            if (pop) void'(exp_q.pop_front());
            if (done && !drop) exp_q.push_back(w);
            m_ovf  = drop | (m_ovf & !clr);
            m_ferr = fe | (m_ferr & !clr);
            if (clr) m_errcnt = int'(drop) + int'(fe);
            else     m_errcnt = m_errcnt + int'(drop) + int'(fe);
            if (m_errcnt > 255) m_errcnt = 255;
        end
    end

    always @(posedge clk) begin
        if (reset && dvalid && dready) delivered <= delivered + 1;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("dvalid", 32'(dvalid), 32'(exp_q.size() > 0));
        check("busy", 32'(busy), 32'(m_pos > 0));
        check("fsm_state", 32'(fsm_state), 32'(m_pos > 0));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("ferr", 32'(ferr), 32'(m_ferr));
        if (exp_q.size() > 0) check("dout", 32'(dout), 32'(exp_q[0]));
`ifdef BSWORD_RX_ERRCNT_EN
        check("errcnt", 32'(errcnt), 32'(m_errcnt));
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [LEN-1:0] w, input bit rdy, input bit rdy_last);
        for (int i = 0; i < LEN; i++) begin
            is     = w[i];
            isync  = (i == 0);
            dready = (i == LEN - 1) ? rdy_last : rdy;
            step();
        end
        isync = 1'b0;
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            is    = 1'($urandom_range(0, 1));
            isync = (i == 0);
            step();
        end
        isync = 1'b0;
    endtask

    task automatic idle(input int n);
        isync = 1'b0;
        for (int i = 0; i < n; i++) begin
            is = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;

        // Reset state
        step();
        step();
        @(negedge clk);
        check("rst_dvalid", 32'(dvalid), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_busy", 32'(busy), 0);
        step();
        reset = 1'b1;
        idle(2);

        // Single word, delivered the cycle after bit 23
        dready = 1'b1;
        send_word(24'hA5C3F1, 1'b1, 1'b1);
        @(negedge clk);
        check("single_dvalid", 32'(dvalid), 1);
        check("single_dout", 32'(dout), 32'h00A5C3F1);
        check("single_busy", 32'(busy), 0);
        step();
        @(negedge clk);
        check("single_drop", 32'(dvalid), 0);

        // Back-to-back overrun with consumer stalled
        send_word(24'h000001, 1'b0, 1'b0);
        send_word(24'h800000, 1'b0, 1'b0);
        send_word(24'h123456, 1'b0, 1'b0);
        @(negedge clk);
        check("ovr_ovf", 32'(ovf), 1);
        check("ovr_head", 32'(dout), 32'h000001);
        dready = 1'b1;
        step();
        @(negedge clk);
        check("ovr_second", 32'(dout), 32'h800000);
        check("ovr_second_v", 32'(dvalid), 1);
        step();
        @(negedge clk);
        check("ovr_empty", 32'(dvalid), 0);

        // Push at full with simultaneous pop
        pulse_clr();
        @(negedge clk);
        check("clr_ovf", 32'(ovf), 0);
        send_word(24'h000001, 1'b0, 1'b0);
        send_word(24'h800000, 1'b0, 1'b0);
        send_word(24'hFFFFFF, 1'b0, 1'b1);
        @(negedge clk);
        check("pwp_ovf", 32'(ovf), 0);
        check("pwp_head", 32'(dout), 32'h800000);
        step();
        @(negedge clk);
        check("pwp_next", 32'(dout), 32'hFFFFFF);
        step();
        @(negedge clk);
        check("pwp_empty", 32'(dvalid), 0);

        // Framing error: sync at bit 0, again at bit 10
        base = delivered;
        dready = 1'b1;
        send_partial(10);
        send_word(24'h0F0F0F, 1'b1, 1'b1);
        @(negedge clk);
        check("ferr_set", 32'(ferr), 1);
        check("ferr_dout", 32'(dout), 32'h0F0F0F);
        step();
        @(negedge clk);
        check("ferr_count", 32'(delivered - base), 1);
        pulse_clr();
        @(negedge clk);
        check("ferr_clr", 32'(ferr), 0);

        // Reset mid-word with a queued word and a framing error pending
        send_word(24'h111111, 1'b0, 1'b0);
        send_partial(5);
        send_partial(12);
        reset = 1'b0;
        #1;
        check("rst_mid_dvalid", 32'(dvalid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ovf", 32'(ovf), 0);
        check("rst_mid_ferr", 32'(ferr), 0);
        idle(2);
        reset = 1'b1;
        idle(2);
        send_word(24'h5A5A5A, 1'b1, 1'b1);
        @(negedge clk);
        check("post_rst_dout", 32'(dout), 32'h5A5A5A);
        check("post_rst_dvalid", 32'(dvalid), 1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            send_word(LEN'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end
        for (int c = 0; c < 3000; c++) begin
            is     = 1'($urandom_range(0, 1));
            isync  = ($urandom_range(0, 99) < 4);
            dready = ($urandom_range(0, 3) != 0);
            clr    = ($urandom_range(0, 199) == 0);
            step();
        end
        isync = 1'b0;
        clr   = 1'b0;

`ifdef BSWORD_RX_ERRCNT_EN
        dready = 1'b1;
        idle(4);
        pulse_clr();
        @(negedge clk);
        check("ec_clr0", 32'(errcnt), 0);
        send_partial(5);
        send_partial(5);
        send_word(LEN'($urandom), 1'b1, 1'b1);
        idle(3);
        for (int n = 0; n < 5; n++) send_word(LEN'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        check("ec_five", 32'(errcnt), 5);
        pulse_clr();
        @(negedge clk);
        check("ec_clr", 32'(errcnt), 0);
        dready = 1'b1;
        idle(4);
        for (int n = 0; n < 301; n++) begin
            is    = 1'($urandom_range(0, 1));
            isync = 1'b1;
            step();
        end
        isync = 1'b0;
        @(negedge clk);
        check("ec_sat", 32'(errcnt), 255);
`endif

        dready = 1'b1;
        idle(30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsword_rx.md
Name: bsword_rx

Overview:
- Bit-serial to parallel word receiver for the serial result streams in the bit-serial arithmetic datapath, such as the modular-multiplier output (q, osync).
- Deserialises LSB-first words framed by a one-cycle sync pulse into LEN-bit parallel words.
- Buffers completed words in a 2-entry FIFO and presents them on a valid/ready interface to the parallel consumer.
- Flags overrun and framing errors.

Parameters:
- LEN, 24, word width in bits; also the bit count per serial frame.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- is  input  1  serial data bit, LSB first.
- isync  input  1  high for one cycle, coincident with bit 0 of a word.
- dout  output  LEN  parallel word at FIFO head.
- dvalid  output  1  dout holds a valid word.
- dready  input  1  consumer accepts dout when dvalid & dready.
- busy  output  1  a word is being assembled (state SHIFT).
- ovf  output  1  sticky: a completed word was dropped because the FIFO was full.
- ferr  output  1  sticky: isync arrived mid-word.
- clr  input  1  synchronous clear of ovf, ferr (and errcnt if built).

Behaviour:
- Reset values: dout=0, dvalid=0, busy=0, ovf=0, ferr=0, FIFO empty, bit counter=0, state IDLE.
- State IDLE:
  - is ignored while isync=0.
  - isync=1: bit 0 is captured, counter becomes 1, state goes to SHIFT.
- State SHIFT:
  - Each cycle shifts is into bit position = counter; counter increments.
  - When the bit at position LEN-1 is captured, the word completes: it is pushed to the FIFO, counter clears and state goes to IDLE.
- Back-to-back frames: isync may arrive in the cycle right after bit LEN-1 (sync period exactly LEN). It is handled as in IDLE with zero gaps.
- Sync mid-word (isync=1 while in SHIFT and counter in 1..LEN-1):
  - The partial word is discarded and ferr is set.
  - The current bit is taken as bit 0 of a new word; counter becomes 1.
- Latency: bit LEN-1 is sampled at edge t. If the FIFO was empty, dout/dvalid update at edge t, so they are visible in the cycle after the last bit.
- FIFO: 2 entries, head on dout, registered outputs.
  - Pop on dvalid & dready.
  - dout holds its value while dvalid & !dready.
- Push while the FIFO is full:
  - Without a pop in the same cycle: the new word is dropped and ovf is set.
  - With a pop in the same cycle: the push is accepted and the FIFO stays full.
- dout is don't-care when dvalid=0, but is held at its last value (no X).
- clr=1 clears ovf/ferr. If a new error occurs in the same cycle, the set wins.
- Reset asserted mid-word or with the FIFO occupied: everything is discarded. The first isync after release starts a clean word.
- Deassert reset synchronously to clk externally. The block has no internal synchroniser.

Optional Feature:
- Macro BSWORD_RX_ERRCNT_EN.
- Defined:
  - Adds output errcnt [7:0]: saturating count (max 255) of dropped words plus framing errors.
  - A cycle with both events adds 2 (saturating).
  - Reset and clr set errcnt to 0.
- Undefined: errcnt port and logic are absent; only sticky ovf/ferr exist.

Test Plan:
- Single word: LEN=24, send 0xA5C3F1 LSB-first with isync on bit 0, dready=1.
  - Response: dvalid=1 for one cycle the cycle after bit 23, dout=0xA5C3F1, busy=0 afterwards.
- Back-to-back overrun: words 0x000001, 0x800000, 0x123456 with zero gaps and dready=0.
  - Response: FIFO holds 0x000001 then 0x800000; third word dropped; ovf=1.
  - Then raise dready: two pops, dvalid drops.
- Push at full with pop: FIFO full, dready=1 in the cycle word 0xFFFFFF completes.
  - Response: ovf stays 0; later pops yield 0x800000 then 0xFFFFFF.
- Framing error: isync at bit 0, then again at bit 10, then 24 bits of 0x0F0F0F.
  - Response: ferr=1; exactly one word delivered, 0x0F0F0F.
  - clr=1 for one cycle -> ferr=0.
- Reset mid-operation: reset=0 at bit 12 of a word with one word already queued.
  - Response: dvalid=0, busy=0, ovf=ferr=0 immediately.
  - After release, word 0x5A5A5A is received correctly.
- With BSWORD_RX_ERRCNT_EN: 3 overruns + 2 framing errors -> errcnt=5; clr -> 0; 300 errors -> errcnt=255.
